// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one spi_drv master among N_REQ requesters.
// Grants one request at a time, sequences the spi_drv command port, returns MISO.
//
// Ports:
//   clk, sreset                  clock, synchronous active-high reset
//   req, req_tx_data, req_n_clks per-requester request level, TX word, bit count
//   grant, done, err             one-hot single-cycle pulses back to requesters
//   rx_data                      received word, length-masked, held until next completion
//   active_id, busy              current/last granted requester, transfer in progress
//   spi_start_cmd, spi_tx_data,
//   spi_n_clks                   command to spi_drv
//   spi_rdy, spi_rx_miso         status and received word from spi_drv
module spi_arbiter #(
    parameter int N_REQ      = 4,
    parameter int SPI_MAXLEN = 16,
    parameter int CW         = $clog2(SPI_MAXLEN) + 1,
    localparam int IW        = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        sreset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*SPI_MAXLEN-1:0] req_tx_data,
    input  logic [N_REQ*CW-1:0]         req_n_clks,
    output logic [N_REQ-1:0]            grant,
    output logic [N_REQ-1:0]            done,
    output logic [N_REQ-1:0]            err,
    output logic [SPI_MAXLEN-1:0]       rx_data,
    output logic [IW-1:0]               active_id,
    output logic                        busy,
    output logic                        spi_start_cmd,
    output logic [SPI_MAXLEN-1:0]       spi_tx_data,
    output logic [CW-1:0]               spi_n_clks,
    input  logic                        spi_rdy,
    input  logic [SPI_MAXLEN-1:0]       spi_rx_miso
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    localparam logic [SPI_MAXLEN:0] ONE = 1;

    state_t              state;
    state_t              state_nxt;
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       win;
    logic [IW-1:0]       win_inc;
    logic                win_vld;
    logic [CW-1:0]       win_len;
    logic                win_legal;
    logic                arb;
    logic [CW-1:0]       cur_len;
    logic                err_q;
    logic [IW-1:0]       err_id;
    logic [SPI_MAXLEN:0] len_ones;

    // Search from rr_ptr upward with wrap; descending loop lets the
    // nearest candidate overwrite the farther ones.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % N_REQ]) begin
                win     = IW'((int'(rr_ptr) + k) % N_REQ);
                win_vld = 1'b1;
            end
        end
    end

    assign win_len   = req_n_clks[win*CW +: CW];
    assign win_legal = (win_len != '0) && (win_len <= CW'(SPI_MAXLEN));
    assign win_inc   = (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
    assign arb       = (state == IDLE) && spi_rdy && win_vld;

    // Ones below the transfer length; a full-length transfer keeps every bit.
    assign len_ones = (ONE << cur_len) - ONE;

    always_comb begin
        state_nxt     = state;
        grant         = '0;
        done          = '0;
        err           = '0;
        busy          = 1'b1;
        spi_start_cmd = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (arb && win_legal) begin
                    state_nxt = START;
                end
            end
            START: begin
                spi_start_cmd     = 1'b1;
                grant[active_id]  = 1'b1;
                state_nxt         = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!spi_rdy) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (spi_rdy) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                done[active_id] = 1'b1;
                state_nxt       = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // A rejected request is answered from IDLE, never overlapping START.
        if (err_q) begin
            grant[err_id] = 1'b1;
            err[err_id]   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            active_id   <= '0;
            cur_len     <= '0;
            err_q       <= 1'b0;
            err_id      <= '0;
            rx_data     <= '0;
            spi_tx_data <= '0;
            spi_n_clks  <= '0;
        end else begin
            state <= state_nxt;
            err_q <= 1'b0;
            if (arb) begin
                rr_ptr <= win_inc;
                if (win_legal) begin
                    spi_tx_data <= req_tx_data[win*SPI_MAXLEN +: SPI_MAXLEN];
                    spi_n_clks  <= win_len;
                    cur_len     <= win_len;
                    active_id   <= win;
                end else begin
                    err_q  <= 1'b1;
                    err_id <= win;
                end
            end
            if (state == START) begin
                spi_tx_data <= '0;
                spi_n_clks  <= '0;
            end
            if ((state == WAIT_DONE) && spi_rdy) begin
                rx_data <= spi_rx_miso & len_ones[SPI_MAXLEN-1:0];
            end
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed and randomized checks of spi_arbiter against a
// transaction-level model, with a behavioural spi_drv loopback stand-in.
module tb_spi_arbiter;

    localparam int N  = 4;
    localparam int L  = 16;
    localparam int CW = 5;

    logic            clk = 1'b0;
    logic            sreset;
    logic [N-1:0]    req;
    logic [N*L-1:0]  req_tx_data;
    logic [N*CW-1:0] req_n_clks;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic [N-1:0]    err;
    logic [L-1:0]    rx_data;
    logic [1:0]      active_id;
    logic            busy;
    logic            spi_start_cmd;
    logic [L-1:0]    spi_tx_data;
    logic [CW-1:0]   spi_n_clks;
    logic            spi_rdy;
    logic [L-1:0]    spi_rx_miso;

    int checks = 0;
    int errors = 0;

    spi_arbiter #(.N_REQ(N), .SPI_MAXLEN(L)) dut (
        .clk           (clk),
        .sreset        (sreset),
        .req           (req),
        .req_tx_data   (req_tx_data),
        .req_n_clks    (req_n_clks),
        .grant         (grant),
        .done          (done),
        .err           (err),
        .rx_data       (rx_data),
        .active_id     (active_id),
        .busy          (busy),
        .spi_start_cmd (spi_start_cmd),
        .spi_tx_data   (spi_tx_data),
        .spi_n_clks    (spi_n_clks),
        .spi_rdy       (spi_rdy),
        .spi_rx_miso   (spi_rx_miso)
    );

    always #5 clk = ~clk;

    // spi_drv stand-in: MOSI looped to MISO. The raw word comes back unmasked
    // so the arbiter's length masking is what clears the upper bits.
    logic [L-1:0] m_tx;
    int           m_cnt;
    always @(posedge clk) begin
        if (sreset) begin
            spi_rdy     <= 1'b1;
            spi_rx_miso <= '0;
            m_cnt       <= 0;
        end else if (spi_rdy) begin
            if (spi_start_cmd) begin
                spi_rdy     <= 1'b0;
                m_tx        <= spi_tx_data;
                m_cnt       <= int'(spi_n_clks) + int'($urandom_range(0, 3));
                spi_rx_miso <= L'($urandom);
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end else begin
            spi_rdy     <= 1'b1;
            spi_rx_miso <= m_tx;
        end
    end

    // Protocol monitor: start pulses are single-cycle and only while ready.
    int viol   = 0;
    int starts = 0;
    int dones  = 0;
    bit prev_start = 1'b0;
    always @(negedge clk) begin
        if (!sreset) begin
            if (spi_start_cmd && (!spi_rdy || prev_start)) viol <= viol + 1;
            if (spi_start_cmd) starts <= starts + 1;
            if (done != '0) dones <= dones + 1;
            prev_start <= spi_start_cmd;
        end else begin
            prev_start <= 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [L-1:0] d, input int n);
        req_tx_data[i*L +: L]  = d;
        req_n_clks[i*CW +: CW] = CW'(n);
    endtask

    // which: 0 grant, 1 done, 2 spi_rdy low
    task automatic wait_sig(input int which, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int c = 0; c < 300 && !ok; c++) begin
            tick;
            n++;
            if (which == 0) ok = (grant != '0);
            else if (which == 1) ok = (done != '0);
            else ok = !spi_rdy;
        end
    endtask

    task automatic do_reset;
        sreset = 1'b1;
        req    = '0;
        tick;
        sreset = 1'b0;
    endtask

    task automatic test_reset;
        sreset      = 1'b1;
        req         = '0;
        req_tx_data = '0;
        req_n_clks  = '0;
        tick;
        tick;
        checks++;
        if ({grant, done, err, busy, spi_start_cmd, active_id} !== '0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0",
                     {grant, done, err, busy, spi_start_cmd, active_id});
        end
        checks++;
        if ({rx_data, spi_tx_data, spi_n_clks} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h want 0",
                     {rx_data, spi_tx_data, spi_n_clks});
        end
        sreset = 1'b0;
    endtask

    task automatic test_single;
        int n;
        bit ok;
        tick;
        tick;
        set_req(1, 16'hBFA3, 16);
        req = 4'b0010;
        tick;
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL single_grant got %b want 0010", grant);
        end
        checks++;
        if ({spi_start_cmd, busy, spi_tx_data, spi_n_clks} !== {2'b11, 16'hBFA3, 5'd16}) begin
            errors++;
            $display("FAIL single_cmd got %b %b %h %0d want 1 1 bfa3 16",
                     spi_start_cmd, busy, spi_tx_data, spi_n_clks);
        end
        req = '0;
        tick;
        checks++;
        if ({spi_start_cmd, busy, spi_tx_data, spi_n_clks} !== {2'b01, 21'd0}) begin
            errors++;
            $display("FAIL single_cleared got %b %b %h %0d want 0 1 0 0",
                     spi_start_cmd, busy, spi_tx_data, spi_n_clks);
        end
        wait_sig(1, n, ok);
        checks++;
        if (!ok || done !== 4'b0010) begin
            errors++;
            $display("FAIL single_done got %b ok=%0d want 0010", done, ok);
        end
        checks++;
        if ({rx_data, active_id} !== {16'hBFA3, 2'd1}) begin
            errors++;
            $display("FAIL single_rx got %h id %0d want bfa3 id 1", rx_data, active_id);
        end
        tick;
        checks++;
        if (busy !== 1'b0 || done !== '0) begin
            errors++;
            $display("FAIL single_idle got busy %b done %b want 0 0000", busy, done);
        end
    endtask

    task automatic test_mask;
        logic [L-1:0] d[2];
        int           nb[2];
        logic [L-1:0] ex[2];
        int           n;
        bit           ok;
        d  = '{16'h12BE, 16'h12A3};
        nb = '{8, 1};
        ex = '{16'h00BE, 16'h0001};
        for (int k = 0; k < 2; k++) begin
            set_req(0, d[k], nb[k]);
            req = 4'b0001;
            tick;
            checks++;
            if (grant !== 4'b0001) begin
                errors++;
                $display("FAIL mask_grant[%0d] got %b want 0001", k, grant);
            end
            req = '0;
            wait_sig(1, n, ok);
            checks++;
            if (!ok || done !== 4'b0001 || rx_data !== ex[k]) begin
                errors++;
                $display("FAIL mask_rx[%0d] got %h done %b want %h 0001",
                         k, rx_data, done, ex[k]);
            end
            tick;
        end
    endtask

    task automatic test_round_robin;
        logic [L-1:0] w[4];
        int           n;
        bit           ok;
        w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        do_reset;
        tick;
        for (int i = 0; i < N; i++) set_req(i, w[i], 16);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_sig(0, n, ok);
            checks++;
            if (!ok || grant !== 4'(1 << (k % N))) begin
                errors++;
                $display("FAIL rr_grant[%0d] got %b want %b", k, grant, 4'(1 << (k % N)));
            end
            if (k > 0) begin
                checks++;
                if (n != 2) begin
                    errors++;
                    $display("FAIL rr_gap[%0d] got %0d want 2", k, n);
                end
            end
            wait_sig(1, n, ok);
            if (k == 4) req = '0;
            checks++;
            if (!ok || done !== 4'(1 << (k % N)) || rx_data !== w[k % N]) begin
                errors++;
                $display("FAIL rr_done[%0d] got %b %h want %b %h",
                         k, done, rx_data, 4'(1 << (k % N)), w[k % N]);
            end
        end
    endtask

    task automatic test_illegal;
        int nb[2];
        int s0;
        int n;
        bit ok;
        nb = '{0, 17};
        tick;
        tick;
        s0 = starts;
        for (int k = 0; k < 2; k++) begin
            set_req(2, 16'hAAAA, nb[k]);
            req = 4'b0100;
            tick;
            checks++;
            if ({err, grant, spi_start_cmd} !== {4'b0100, 4'b0100, 1'b0}) begin
                errors++;
                $display("FAIL illegal_pulse[%0d] got err %b grant %b start %b want 0100 0100 0",
                         k, err, grant, spi_start_cmd);
            end
            req = '0;
            tick;
            checks++;
            if ({err, grant, busy} !== '0) begin
                errors++;
                $display("FAIL illegal_single[%0d] got err %b grant %b busy %b want 0",
                         k, err, grant, busy);
            end
        end
        tick;
        tick;
        checks++;
        if (starts != s0) begin
            errors++;
            $display("FAIL illegal_nostart got %0d starts want %0d", starts, s0);
        end
        set_req(2, 16'h5A5A, 16);
        set_req(3, 16'hC3C3, 12);
        req = 4'b1100;
        tick;
        checks++;
        if (grant !== 4'b1000) begin
            errors++;
            $display("FAIL illegal_ptr got %b want 1000", grant);
        end
        req = 4'b0100;
        wait_sig(1, n, ok);
        checks++;
        if (!ok || done !== 4'b1000 || rx_data !== 16'h03C3) begin
            errors++;
            $display("FAIL illegal_after got %b %h want 1000 03c3", done, rx_data);
        end
        wait_sig(0, n, ok);
        req = '0;
        checks++;
        if (!ok || grant !== 4'b0100) begin
            errors++;
            $display("FAIL illegal_next got %b want 0100", grant);
        end
        wait_sig(1, n, ok);
        checks++;
        if (!ok || rx_data !== 16'h5A5A) begin
            errors++;
            $display("FAIL illegal_next_rx got %h want 5a5a", rx_data);
        end
    endtask

    task automatic test_reset_mid;
        int d0;
        int n;
        bit ok;
        tick;
        tick;
        set_req(1, 16'hFFFF, 16);
        req = 4'b0010;
        tick;
        req = '0;
        wait_sig(2, n, ok);
        tick;
        checks++;
        if (!ok || busy !== 1'b1) begin
            errors++;
            $display("FAIL rmid_busy got busy %b ok %0d want 1", busy, ok);
        end
        sreset = 1'b1;
        tick;
        d0 = dones;
        checks++;
        if ({grant, done, err, busy, spi_start_cmd, active_id} !== '0 ||
            {rx_data, spi_tx_data, spi_n_clks} !== '0) begin
            errors++;
            $display("FAIL rmid_zero got %b %h want 0",
                     {grant, done, err, busy, spi_start_cmd, active_id},
                     {rx_data, spi_tx_data, spi_n_clks});
        end
        sreset = 1'b0;
        repeat (40) tick;
        checks++;
        if (dones != d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_nodone got dones %0d busy %b want %0d 0", dones, busy, d0);
        end
        set_req(0, 16'h0F0F, 16);
        set_req(1, 16'h7777, 16);
        req = 4'b0011;
        tick;
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL rmid_prio got %b want 0001", grant);
        end
        req = 4'b0010;
        wait_sig(1, n, ok);
        checks++;
        if (!ok || done !== 4'b0001 || rx_data !== 16'h0F0F) begin
            errors++;
            $display("FAIL rmid_rx got %b %h want 0001 0f0f", done, rx_data);
        end
        wait_sig(0, n, ok);
        req = '0;
        wait_sig(1, n, ok);
    endtask

    // Model: pending set per round; winner is nearest pending index at or
    // after the model pointer; expected data is the word modulo 2**len.
    task automatic test_random;
        logic [L-1:0] rd[N];
        int           rn[N];
        logic [N-1:0] pend;
        int           m_ptr;
        int           w;
        int           budget;
        int           n;
        bit           ok;
        bit           legal;
        logic [L-1:0] ex;
        do_reset;
        tick;
        m_ptr = 0;
        for (int r = 0; r < 40; r++) begin
            pend = N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                int sel;
                rd[i] = L'($urandom);
                sel   = int'($urandom_range(0, 9));
                if (sel == 0) rn[i] = 0;
                else if (sel == 1) rn[i] = int'($urandom_range(17, 31));
                else rn[i] = int'($urandom_range(1, 16));
                set_req(i, rd[i], rn[i]);
            end
            req    = pend;
            budget = 2000;
            while (pend != '0 && budget > 0) begin
                tick;
                budget--;
                if (grant != '0) begin
                    w = -1;
                    for (int k = N - 1; k >= 0; k--) begin
                        if (pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                    end
                    legal = (rn[w] >= 1) && (rn[w] <= L);
                    checks++;
                    if (grant !== 4'(1 << w)) begin
                        errors++;
                        $display("FAIL rnd_grant[%0d] got %b want %b", r, grant, 4'(1 << w));
                    end
                    checks++;
                    if (legal ? (err !== '0 || spi_start_cmd !== 1'b1)
                              : (err !== grant || spi_start_cmd !== 1'b0)) begin
                        errors++;
                        $display("FAIL rnd_kind[%0d] len %0d got err %b start %b",
                                 r, rn[w], err, spi_start_cmd);
                    end
                    m_ptr   = (w + 1) % N;
                    pend[w] = 1'b0;
                    req[w]  = 1'b0;
                    if (legal) begin
                        ex = L'(int'(rd[w]) % (1 << rn[w]));
                        wait_sig(1, n, ok);
                        checks++;
                        if (!ok || done !== 4'(1 << w) || rx_data !== ex ||
                            active_id !== 2'(w)) begin
                            errors++;
                            $display("FAIL rnd_done[%0d] got %b %h id %0d want %b %h id %0d",
                                     r, done, rx_data, active_id, 4'(1 << w), ex, w);
                        end
                    end
                end
            end
            checks++;
            if (pend != '0) begin
                errors++;
                $display("FAIL rnd_timeout[%0d] got pending %b want 0000", r, pend);
            end
            req = '0;
            tick;
            tick;
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_mask;
        test_round_robin;
        test_illegal;
        test_reset_mid;
        test_random;
        tick;
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL start_protocol got %0d violations want 0", viol);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
